// File: rtl/bcd_latch_bank_if.sv
// Bus between the counter chain / gate controller and the display latch bank.
// master drives the count and control inputs, slave is the latch bank.
interface bcd_latch_bank_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] deci;
  logic                ovf_in;
  logic                lock;
  logic                hold;
  logic                clr;
  logic [4*DIGITS-1:0] latchout;
  logic [DIGITS-1:0]   blank;
  logic                ovf_out;
  logic                err;
  logic                upd;
  logic                miss;

  modport master (
    output deci, ovf_in, lock, hold, clr,
    input  latchout, blank, ovf_out, err, upd, miss
  );

  modport slave (
    input  deci, ovf_in, lock, hold, clr,
    output latchout, blank, ovf_out, err, upd, miss
  );
endinterface

// File: rtl/bcd_latch_bank.sv
// Display latch for the frequency meter: captures the BCD count on each lock rise,
// with hold/freeze, overflow and non-BCD flagging, clear and leading-zero blanking.
module bcd_latch_bank #(
  parameter int DIGITS   = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_latch_bank_if.slave  bus
);
  localparam int W = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST =
    BLANK_LZ ? {{(DIGITS-1){1'b1}}, 1'b0} : {DIGITS{1'b0}};

  function automatic logic [W-1:0] sanitize(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'hF;
      else                    r[4*i +: 4] = d[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic non_bcd(input logic [W-1:0] d);
    logic e;
    e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      e = e | (d[4*i +: 4] > 4'd9);
    end
    return e;
  endfunction

  function automatic logic [DIGITS-1:0] blank_mask(input logic [W-1:0] d);
    logic [DIGITS-1:0] m;
    logic              zr;
    m  = {DIGITS{1'b0}};
    zr = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zr   = zr & (d[4*i +: 4] == 4'h0);
      m[i] = zr & BLANK_LZ;
    end
    return m;
  endfunction

  logic          s1_q, s2_q, s3_q, h_q;
  logic [1:0]    init_q;
  logic          arm_q, arm_d;
  logic [W-1:0]  sh_data_q, sh_data_d;
  logic          sh_ovf_q, sh_ovf_d, sh_err_q, sh_err_d;
  logic [W-1:0]  disp_q, disp_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic          ovf_q, ovf_d, err_q, err_d, upd_q, upd_d, miss_q, miss_d;
  logic [W-1:0]  cap_data_s;
  logic          cap_err_s, cap_s, hold_fall_s;

  // lock synchroniser, edge register and hold history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      h_q    <= 1'b0;
      init_q <= 2'd0;
    end else begin
      s1_q   <= bus.lock;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      h_q    <= bus.hold;
      init_q <= (init_q == 2'd2) ? init_q : init_q + 2'd1;
    end
  end

  // arm_q only rises once the synchronised lock has been seen low after reset,
  // so a lock level still high across reset release never counts as a rise.
  always_comb begin
    cap_data_s  = sanitize(bus.deci);
    cap_err_s   = non_bcd(bus.deci);
    cap_s       = s2_q & ~s3_q & arm_q;
    hold_fall_s = h_q & ~bus.hold;
    arm_d       = arm_q | ((init_q == 2'd2) & ~s2_q);
    sh_data_d   = sh_data_q;
    sh_ovf_d    = sh_ovf_q;
    sh_err_d    = sh_err_q;
    disp_d      = disp_q;
    blank_d     = blank_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    miss_d      = miss_q;
    upd_d       = 1'b0;
    if (bus.clr) begin
      sh_data_d = {W{1'b0}};
      sh_ovf_d  = 1'b0;
      sh_err_d  = 1'b0;
      disp_d    = {W{1'b0}};
      blank_d   = BLANK_RST;
      ovf_d     = 1'b0;
      err_d     = 1'b0;
      miss_d    = 1'b0;
    end else if (cap_s) begin
      sh_data_d = cap_data_s;
      sh_ovf_d  = bus.ovf_in;
      sh_err_d  = cap_err_s;
      if (!bus.hold) begin
        disp_d  = cap_data_s;
        blank_d = blank_mask(cap_data_s);
        ovf_d   = bus.ovf_in;
        err_d   = cap_err_s;
        miss_d  = 1'b0;
        upd_d   = 1'b1;
      end else begin
        miss_d  = 1'b1;
      end
    end else if (hold_fall_s && miss_q) begin
      disp_d  = sh_data_q;
      blank_d = blank_mask(sh_data_q);
      ovf_d   = sh_ovf_q;
      err_d   = sh_err_q;
      miss_d  = 1'b0;
      upd_d   = 1'b1;
    end else begin
      upd_d   = 1'b0;
    end
  end

  // shadow and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q     <= 1'b0;
      sh_data_q <= {W{1'b0}};
      sh_ovf_q  <= 1'b0;
      sh_err_q  <= 1'b0;
      disp_q    <= {W{1'b0}};
      blank_q   <= BLANK_RST;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      upd_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      arm_q     <= arm_d;
      sh_data_q <= sh_data_d;
      sh_ovf_q  <= sh_ovf_d;
      sh_err_q  <= sh_err_d;
      disp_q    <= disp_d;
      blank_q   <= blank_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.latchout = disp_q;
  assign bus.blank    = blank_q;
  assign bus.ovf_out  = ovf_q;
  assign bus.err      = err_q;
  assign bus.upd      = upd_q;
  assign bus.miss     = miss_q;
endmodule

// File: doc/bcd_latch_bank.md
# bcd_latch_bank

Parametrised display latch for the frequency meter, sitting between the BCD counter chain and the seven-segment scanner. It captures an N-digit BCD count on each rising edge of the gate controller's `lock` strobe, synchronised to the system clock. It adds overflow/error flagging, a display-freeze (`hold`) mode that still tracks the newest measurement, synchronous clear and registered leading-zero blanking. It replaces the fixed 4-digit, clockless latch.

## Interface
- `DIGITS`, 4, number of BCD digits (≥2); digit 0 is the least significant.
- `BLANK_LZ`, 1, 1 = generate the leading-zero blank mask; 0 = mask is always 0.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `deci`  in  4*DIGITS  BCD count from the counter chain; digit i is bits [4i+3:4i]; stable while `lock` rises.
- `ovf_in`  in  1  counter overflow, sampled together with `deci`.
- `lock`  in  1  gate-end strobe, asynchronous to `clk`, high ≥3 clk periods.
- `hold`  in  1  synchronous level; freezes the display outputs.
- `clr`  in  1  synchronous clear pulse.
- `latchout`  out  4*DIGITS  displayed BCD value.
- `blank`  out  DIGITS  1 = digit i is a leading zero, so the scanner blanks it.
- `ovf_out`  out  1  overflow flag of the displayed value.
- `err`  out  1  displayed value contained a non-BCD digit.
- `upd`  out  1  one-cycle pulse when the display registers change due to new data.
- `miss`  out  1  a capture occurred while `hold` was high and has not yet been shown.

## Operation
- Shadow registers (`sh_data`, `sh_ovf`, `sh_err`) capture on every detected `lock` rise, regardless of `hold`.
- Display registers (`latchout`, `blank`, `ovf_out`, `err`) are loaded from the capture path:
  - when a capture occurs with `hold`=0, or
  - from the shadow registers on the first cycle after a `hold` 1→0 transition while `miss`=1.
- Digit sanitising at capture: any digit >9 is stored as 4'hF and sets `err` for that capture. `err` is recomputed on every capture; it is not sticky.
- Blank mask: `blank[i]`=1 iff `BLANK_LZ`=1, i≥1, and digits i..DIGITS-1 are all 0. Digit 0 is never blanked. A 4'hF digit counts as non-zero. The mask is computed from the value being loaded and is registered with `latchout`.
- `ovf_out` follows `ovf_in` as sampled at capture; the data is not altered.
- `miss`:
  - set when a capture occurs with `hold`=1;
  - cleared when the shadow is transferred to the display, or by `clr`.
- `clr` clears shadow and display registers and `miss`, and suppresses any capture or transfer in the same cycle. `clr` has highest priority after reset.
- Simultaneous capture and `hold` falling edge: the capture path loads the display directly (newest data wins); `miss` clears and `upd` pulses once.

## Timing
- `lock` passes through a 2-FF synchroniser (s1, s2) and an edge register s3. Capture is enabled when s2=1 and s3=0.
- If `lock` is first sampled high at edge k:
  - s1 goes high at k and s2 at k+1;
  - capture occurs at edge k+2;
  - `latchout` shows the new value after edge k+2;
  - `upd` is high for exactly the cycle following edge k+2.
- `deci`/`ovf_in` are sampled directly at edge k+2. The counter chain holds them stable ≥3 cycles after `lock` rises.
- `hold` is used registered (h_q) for edge detection. Transfer happens at the edge after the one where h_q=1 and `hold`=0; `upd` pulses in the following cycle.
- Only one capture occurs per `lock` high period. Re-arming requires s2 to return to 0.
- Reset (async assert, synchronous de-assert handled upstream):
  - `latchout`=0, `ovf_out`=0, `err`=0, `upd`=0, `miss`=0;
  - `blank`={DIGITS-1 ones, 0} if `BLANK_LZ`, else 0;
  - synchroniser, shadow and h_q are 0.
- Reset asserted mid-capture aborts it. No `upd` follows de-assertion until a fresh `lock` rise.
- Latency `lock`→display is 2–3 clk edges, depending on the sample phase.

## Test plan
- Reset, then `deci`=16'h0042, `lock` pulse for 4 cycles → at edge k+2 `latchout`=16'h0042, `blank`=4'b1100, `upd` high for 1 cycle, `ovf_out`=0, `err`=0.
- `deci`=16'h12A5, `ovf_in`=1, `lock` pulse → `latchout`=16'h12F5, `err`=1, `ovf_out`=1, `blank`=4'b0000. Next capture of 16'h0007 → `err`=0, `blank`=4'b1110.
- Display 16'h0100, raise `hold`, capture 16'h0250 → display stays 16'h0100, no `upd`, `miss`=1. Drop `hold` → `latchout`=16'h0250, `upd` for one cycle, `miss`=0.
- `hold` falling edge in the same cycle as a capture of 16'h0999 (with stale shadow 16'h0888) → `latchout`=16'h0999, exactly one `upd`, `miss`=0.
- `clr` asserted on the capture cycle → outputs show the reset values, no `upd`. With `BLANK_LZ`=0 and `DIGITS`=6, `deci`=24'h000300 → `blank`=0.
- `lock` held high for 20 cycles → exactly one capture. Assert `rst_n` low at edge k+1 → outputs reset, no capture and no `upd` after release.
